uart_rx_fsm: RTL
================

// Module: uart_rx_fsm
// PURPOSE
//  Control FSM and deserializer of the UART receiver.
//  - Drives the enable of the edge/bit counter and consumes its edge_cnt/bit_cnt.
//  - Consumes the majority-voted bit from the data sampler.
//  - Checks the start, parity and stop bits and assembles the parallel byte.
//  - Sits between the RX line and the system-side register/FIFO that takes P_DATA on data_valid.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, LSB first; legal 5..8
// PORTS
//  clk          in   1           receiver oversampling clock
//  rst_n        in   1           asynchronous reset, active low
//  rx_in        in   1           serial line, already synchronized to clk; idle high
//  par_en       in   1           1 = frame carries a parity bit
//  par_typ      in   1           0 = even parity, 1 = odd parity
//  Prescale     in   6           oversampling ratio; legal 8, 16, 32
//  edge_cnt     in   5           edge count within the current bit (from the counter)
//  bit_cnt      in   4           bit index within the frame (from the counter)
//  sampled_bit  in   1           voted bit value (from the data sampler)
//  edge_bit_en  out  1           counter enable
//  dat_samp_en  out  1           data sampler enable
//  P_DATA       out  DATA_WIDTH  last good frame payload
//  data_valid   out  1           1-cycle strobe: P_DATA updated
//  par_err      out  1           parity error flag for the last frame
//  stp_err      out  1           stop error flag for the last frame
// BEHAVIOUR
//  Reset values:
//  - state = IDLE.
//  - All outputs 0; P_DATA = 0; shift register = 0.
//  Counter contract:
//  - While enable = 1, edge_cnt counts 0..Prescale-1 and then wraps.
//  - bit_cnt increments on each wrap.
//  - While enable = 0, both counts clear to 0 on the next clock.
//  Sampler contract:
//  - sampled_bit is stable from edge_cnt = Prescale/2+2 to Prescale-1 of each bit.
//  bit_end = (edge_cnt == Prescale-1).
//  - This is the only point where the FSM evaluates sampled_bit or advances state.
//  Moore outputs:
//  - edge_bit_en = dat_samp_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
//  States:
//  - IDLE:
//    - rx_in = 0 -> START next clock (1 cycle detect latency; counter starts at 0).
//    - Entering START clears par_err and stp_err.
//  - START, at bit_end:
//    - sampled_bit = 0 -> DATA.
//    - sampled_bit = 1 -> glitch: back to IDLE. No flags, no strobe.
//  - DATA, at bit_end:
//    - shift = {sampled_bit, shift[DATA_WIDTH-1:1]} (LSB received first).
//    - If bit_cnt = DATA_WIDTH: go to PARITY if par_en, else STOP.
//  - PARITY, at bit_end:
//    - par_err <= sampled_bit != (^shift ^ par_typ).
//    - -> STOP.
//  - STOP, at bit_end:
//    - stp_err <= ~sampled_bit.
//    - -> IDLE.
//    - If the stop bit is good and there is no parity error: P_DATA <= shift and data_valid = 1
//      for exactly the next cycle. Otherwise P_DATA holds and there is no strobe.
//  Flags hold their value until the next START entry.
//  Back-to-back frames:
//  - A start edge seen in the first IDLE cycle after STOP is accepted normally.
//  - No idle gap is needed beyond 1 clk.
//  Widths and stability:
//  - Prescale-1 is compared at 5 bits.
//  - Prescale and par_en/par_typ must be stable while state != IDLE.
//  - Changing them mid-frame is undefined.
//  Reset mid-frame:
//  - Immediate return to IDLE with all outputs 0.
//  - The partial byte is discarded.
// STRUCTURE
//  Shared header uart_rx_defs.vh:
//  - State encodings IDLE/START/DATA/PARITY/STOP (3-bit, binary).
//  - PAR_EVEN = 1'b0, PAR_ODD = 1'b1.
//  Natural sub-module: uart_rx_deser.
//  - Holds the shift register, parity compute and P_DATA register.
//  - Enabled by the FSM with shift_en / load_en.
//  The FSM itself stays a single 2-process state machine in this file.
//  The edge/bit counter and the data sampler are instantiated by the parent uart_rx.
// TESTING
//  Bench wraps this block with the real edge/bit counter and data sampler. Prescale = 8 unless noted.
//  1. 0xA5, par_en=1, even, good parity and stop -> data_valid 1 cycle, P_DATA = 8'hA5, par_err = stp_err = 0.
//  2. 0x3C, par_en=1, odd, parity bit sent = 0 (wrong) -> par_err = 1, no data_valid, P_DATA unchanged.
//  3. 0x81, par_en=0, stop bit driven 0 -> stp_err = 1, no data_valid; next good frame clears stp_err.
//  4. rx_in low for 2 clk then high -> START aborts to IDLE at bit_end, no flags; edge_bit_en low afterwards.
//  5. Prescale = 16 and 32, two back-to-back frames 0x55, 0xAA -> two strobes, P_DATA = 55 then AA.
//  6. rst_n pulsed low during DATA bit 4 -> outputs 0 at once; following frame 0x0F received correctly.

Source files
------------

// File: rtl/uart_rx_fsm_pkg.sv
// Purpose : shared state encodings, parity-type constants and parity helper for the UART RX FSM.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package uart_rx_fsm_pkg;

    typedef logic [2:0] state_t;

    // Binary state encoding, kept as plain constants so legacy tools can read it.
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit the transmitter should have sent, given the XOR of the payload.
    function automatic logic f_exp_parity(input logic i_data_xor, input logic i_par_typ);
        return i_data_xor ^ i_par_typ;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_deser.sv
// Purpose : LSB-first shift register, expected-parity compute and payload output register.
// Latency : shift/load take effect on the clock where the enable is high.
// Backpressure: none; the consumer must take o_data on the FSM's data_valid strobe.
// Ports   : i_shift_en shifts i_bit in at the MSB; i_load_en copies the shift register to o_data;
//           o_exp_par is the parity bit expected for the current shift contents under i_par_typ.
module uart_rx_fsm_deser
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_shift_en,
    input  logic                  i_load_en,
    input  logic                  i_bit,
    input  logic                  i_par_typ,
    output logic                  o_exp_par,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;

    // First received bit ends up in bit 0 after DATA_WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (i_shift_en) begin
            r_shift <= {i_bit, r_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load_en) begin
            r_data <= r_shift;
        end
    end

    assign o_exp_par = f_exp_parity(^r_shift, i_par_typ);
    assign o_data    = r_data;

endmodule

// File: rtl/uart_rx_fsm.sv
// Purpose : UART receive control FSM; checks start/parity/stop and strobes out the assembled byte.
// Latency : start detected 1 clk after rx_in falls; data_valid 1 clk after the stop bit's last edge.
// Backpressure: none; data_valid is a single-cycle strobe the downstream must accept.
// Ports   : rx_in serial line; par_en/par_typ/Prescale frame config; edge_cnt/bit_cnt from the
//           edge/bit counter; sampled_bit from the voting sampler; edge_bit_en/dat_samp_en enables;
//           P_DATA last good payload; data_valid strobe; par_err/stp_err flags of the last frame.
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            Prescale,
    input  logic [4:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    input  logic                  sampled_bit,
    output logic                  edge_bit_en,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    state_t r_state;
    state_t w_next;

    logic       r_par_err;
    logic       r_stp_err;
    logic       r_data_valid;

    logic [4:0] w_last_edge;
    logic       w_bit_end;
    logic       w_last_data;
    logic       w_start_entry;
    logic       w_shift_en;
    logic       w_par_end;
    logic       w_stop_end;
    logic       w_load_en;
    logic       w_exp_par;
    logic       w_busy;

    // Prescale 32 wraps to 0 at 5 bits, so Prescale-1 lands on 31 as required.
    assign w_last_edge   = 5'(Prescale - 6'd1);
    assign w_bit_end     = (edge_cnt == w_last_edge);
    assign w_last_data   = (bit_cnt == 4'(DATA_WIDTH));

    assign w_start_entry = (r_state == ST_IDLE) && !rx_in;
    assign w_shift_en    = (r_state == ST_DATA) && w_bit_end;
    assign w_par_end     = (r_state == ST_PARITY) && w_bit_end;
    assign w_stop_end    = (r_state == ST_STOP) && w_bit_end;
    // Parity flag is already settled by the stop bit, so it can gate the load directly.
    assign w_load_en     = w_stop_end && sampled_bit && !r_par_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!rx_in) w_next = ST_START;
            end
            ST_START: begin
                // A high vote at the end of the start bit means the falling edge was a glitch.
                if (w_bit_end) w_next = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && w_last_data) w_next = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_end) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Flags describe the most recent frame and survive until the next start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_load_en;
            if (w_start_entry) begin
                r_par_err <= 1'b0;
                r_stp_err <= 1'b0;
            end
            if (w_par_end) r_par_err <= (sampled_bit != w_exp_par);
            if (w_stop_end) r_stp_err <= ~sampled_bit;
        end
    end

    uart_rx_fsm_deser #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_shift_en (w_shift_en),
        .i_load_en  (w_load_en),
        .i_bit      (sampled_bit),
        .i_par_typ  (par_typ),
        .o_exp_par  (w_exp_par),
        .o_data     (P_DATA)
    );

    assign w_busy      = (r_state != ST_IDLE);
    assign edge_bit_en = w_busy;
    assign dat_samp_en = w_busy;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;

endmodule
